ram_rd_check: RTL and testbench
===============================

RAM_RD_CHECK -- requirements
Module: ram_rd_check

Interface
REQ-001 SHALL have parameter AW, default 6, RAM address width.
REQ-002 SHALL have parameter DW, default 8, RAM data width.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rd_flag  input  1  writer pass-complete indication from the write side.
REQ-006 SHALL have port ram_rd_en  output  1  RAM port B enable.
REQ-007 SHALL have port ram_rd_addr  output  AW  RAM port B address.
REQ-008 SHALL have port ram_rd_data  input  DW  RAM port B read data, valid 1 cycle after en/addr.
REQ-009 SHALL have port busy  output  1  high from pass start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of each read pass.
REQ-011 SHALL have port err  output  1  sticky mismatch flag for current/last pass.
REQ-012 SHALL have port err_cnt  output  AW+1  mismatch count for current/last pass.
REQ-013 SHALL have port first_err_addr  output  AW  address of first mismatch in current/last pass.

Function
REQ-014 SHALL implement FSM states IDLE, READ, DRAIN, DONE; DEPTH = 2**AW words per pass.
REQ-015 SHALL start a pass only on rd_flag rising edge (registered rd_flag low -> high) sampled in IDLE; edges seen outside IDLE SHALL be ignored, with no queuing.
REQ-016 SHALL, on start: go to READ, clear err, err_cnt and first_err_addr, drive addr 0, assert busy.
REQ-017 SHALL, in READ: hold ram_rd_en=1 and increment ram_rd_addr by 1 per cycle from 0 to DEPTH-1, one address per cycle, no gaps.
REQ-018 SHALL, in READ with addr = DEPTH-1: go to DRAIN next cycle; ram_rd_en=0 and addr=0 in DRAIN.
REQ-019 SHALL go from DRAIN to DONE after one cycle, with the last compare done in DRAIN; DONE SHALL pulse done=1 for exactly one cycle, drop busy, and return to IDLE.
REQ-020 SHALL register the read strobe and address to form cmp_valid/cmp_addr exactly 1 cycle after ram_rd_en/ram_rd_addr.
REQ-021 SHALL compare ram_rd_data against expected = cmp_addr zero-extended or truncated to DW when cmp_valid=1.
REQ-022 SHALL, on mismatch: set err, increment err_cnt (saturating at 2**(AW+1)-1, never wrapping), and capture first_err_addr if err was 0.
REQ-023 SHALL hold err, err_cnt and first_err_addr stable after DONE until the next start.
REQ-024 SHALL complete a pass in DEPTH+3 cycles from the start edge: DEPTH READ, 1 DRAIN, 1 DONE, 1 edge-detect.
REQ-025 SHALL tolerate rd_flag held high for a whole pass; a new pass requires rd_flag low then high again.

Reset
REQ-026 SHALL, while rst=0, asynchronously force: FSM=IDLE, ram_rd_en=0, ram_rd_addr=0, busy=0, done=0, err=0, err_cnt=0, first_err_addr=0, and clear the edge-detect and compare pipeline registers.
REQ-027 SHALL abort a pass when reset asserts mid-pass, with no done pulse; after release, a fresh rd_flag rising edge is required to start.

Structure
REQ-028 SHALL take AW/DW defaults, DEPTH derivation and the FSM state encoding from shared package ram_demo_pkg, which the writer side also uses.
REQ-029 SHALL be a single module; the compare/count stage MAY be split into sub-module ram_rd_cmp (inputs: cmp_valid, cmp_addr, data, start; outputs: err, err_cnt, first_err_addr).

Verification
REQ-030 Clean pass: RAM preloaded with data = addr, AW=6, DW=8, rd_flag 0 -> 1 -> addresses 0..63 on consecutive cycles, done pulse at cycle 67, err=0, err_cnt=0.
REQ-031 Single corruption: word 17 = 0xFF -> err=1, err_cnt=1, first_err_addr=17 after done.
REQ-032 Multiple corruptions at 5, 40, 63 -> err_cnt=3, first_err_addr=5; the next clean pass clears all three outputs to 0.
REQ-033 rd_flag held high through a pass and beyond -> exactly one pass, one done pulse; a low -> high toggle during READ is ignored.
REQ-034 Reset asserted at addr 30 of READ -> all outputs 0 immediately, no done pulse; next rd_flag edge -> a full pass from addr 0.
REQ-035 Saturation with AW=2, DW=8 and an all-wrong RAM over repeated passes -> err_cnt=4 per pass, cleared at each start, never wraps.

Source files
------------

// File: rtl/ram_demo_pkg.sv
// ram_demo_pkg: definitions shared by the RAM demo writer and reader sides.
//   AW_DEF / DW_DEF : default RAM address / data width
//   rd_state_e      : reader FSM state encoding
//   depth_of()      : words per pass for a given address width
package ram_demo_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ram_rd_cmp.sv
// ram_rd_cmp: compares RAM read data against the address-pattern and keeps
// the per-pass error status.
//   clk, rst        : clock, async active-low reset
//   start           : clears status at the start of a pass
//   cmp_valid       : data on 'data' belongs to cmp_addr
//   cmp_addr        : address of the word being compared
//   data            : RAM read data
//   err             : sticky mismatch flag
//   err_cnt         : saturating mismatch count
//   first_err_addr  : address of the first mismatch of the pass
module ram_rd_cmp
  import ram_demo_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cmp_valid,
  input  logic [AW-1:0] cmp_addr,
  input  logic [DW-1:0] data,
  output logic          err,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [AW:0] CNT_MAX = '1;

  logic          err_q,   err_d;
  logic [AW:0]   cnt_q,   cnt_d;
  logic [AW-1:0] first_q, first_d;
  logic [DW-1:0] exp_data;
  logic          mismatch;

  always_comb begin
    // expected word is the address itself, zero-extended or truncated
    exp_data = DW'(cmp_addr);
    mismatch = cmp_valid && (data != exp_data);
    err_d    = err_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    if (start) begin
      err_d   = 1'b0;
      cnt_d   = '0;
      first_d = '0;
    end else if (mismatch) begin
      err_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (!err_q) first_d = cmp_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q   <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign err            = err_q;
  assign err_cnt        = cnt_q;
  assign first_err_addr = first_q;

endmodule

// File: rtl/ram_rd_check.sv
// ram_rd_check: on each writer pass-complete edge, reads the whole RAM once
// through port B and checks every word equals its own address.
//   clk, rst        : clock, async active-low reset
//   rd_flag         : writer pass-complete level; rising edge starts a pass
//   ram_rd_en/addr  : RAM port B strobe and address
//   ram_rd_data     : RAM port B data, one cycle after the strobe
//   busy, done      : pass in progress / one-cycle end-of-pass pulse
//   err, err_cnt, first_err_addr : status of the current/last pass
//
// state    | meaning
// ST_IDLE  | waiting for rd_flag rising edge
// ST_READ  | issuing addresses 0..DEPTH-1, one per cycle
// ST_DRAIN | strobe off, last word still being compared
// ST_DONE  | done pulse, status frozen until next start
module ram_rd_check
  import ram_demo_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_flag,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr
);

  localparam int            DEPTH     = depth_of(AW);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  rd_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_flag_q, rd_flag_d;
  logic          rd_flag_prev_q, rd_flag_prev_d;
  logic          cmp_valid_q, cmp_valid_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic          rise;
  logic          start;

  // edge detect runs on the registered flag, costing one cycle of latency
  assign rise  = rd_flag_q && !rd_flag_prev_q;
  assign start = (state_q == ST_IDLE) && rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      rd_flag_q      <= 1'b0;
      rd_flag_prev_q <= 1'b0;
      cmp_valid_q    <= 1'b0;
      cmp_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rd_flag_q      <= rd_flag_d;
      rd_flag_prev_q <= rd_flag_prev_d;
      cmp_valid_q    <= cmp_valid_d;
      cmp_addr_q     <= cmp_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = '0;
    rd_flag_d      = rd_flag;
    rd_flag_prev_d = rd_flag_q;
    cmp_valid_d    = ram_rd_en;
    cmp_addr_d     = ram_rd_addr;
    case (state_q)
      ST_IDLE:  if (rise) state_d = ST_READ;
      ST_READ: begin
        if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
        else                     addr_d  = addr_q + 1'b1;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_rd_en   = (state_q == ST_READ);
    ram_rd_addr = addr_q;
    busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
    done        = (state_q == ST_DONE);
  end

  ram_rd_cmp #(
    .AW (AW),
    .DW (DW)
  ) u_cmp (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cmp_valid      (cmp_valid_q),
    .cmp_addr       (cmp_addr_q),
    .data           (ram_rd_data),
    .err            (err),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_ram_rd_check.sv
// tb_ram_rd_check: directed bench for ram_rd_check with a behavioural RAM.
// Expected read addresses are queued when a pass is launched and popped as
// the reader issues them; end-of-pass status is checked at the done pulse.
module tb_ram_rd_check;

  localparam int AW     = 6;
  localparam int DW     = 8;
  localparam int DEPTH  = 64;
  localparam int AW2    = 2;
  localparam int DEPTH2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rd_flag;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic          busy, done, err;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] first_err_addr;

  logic           rd_flag2;
  logic           ram_rd_en2;
  logic [AW2-1:0] ram_rd_addr2;
  logic [DW-1:0]  ram_rd_data2 = '0;
  logic           busy2, done2, err2;
  logic [AW2:0]   err_cnt2;
  logic [AW2-1:0] first_err_addr2;

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] mem2 [DEPTH2];

  always @(posedge clk) if (ram_rd_en)  ram_rd_data  <= mem[ram_rd_addr];
  always @(posedge clk) if (ram_rd_en2) ram_rd_data2 <= mem2[ram_rd_addr2];

  ram_rd_check #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .rd_flag(rd_flag),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr)
  );

  ram_rd_check #(.AW(AW2), .DW(DW)) dut2 (
    .clk(clk), .rst(rst), .rd_flag(rd_flag2),
    .ram_rd_en(ram_rd_en2), .ram_rd_addr(ram_rd_addr2), .ram_rd_data(ram_rd_data2),
    .busy(busy2), .done(done2), .err(err2), .err_cnt(err_cnt2),
    .first_err_addr(first_err_addr2)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clean_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
  endtask

  // One full pass on the AW=6 instance. toggle: drop/raise rd_flag mid-READ.
  // hold: keep rd_flag high for a while after the pass.
  task automatic pass6(input int ecnt, input int efirst, input bit toggle, input bit hold);
    int done_cyc;
    int reads;
    int extra;
    int e;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(i);
    done_cyc = -1;
    reads    = 0;
    rd_flag  = 1'b1;
    for (int n = 1; n <= 200 && done_cyc < 0; n++) begin
      tick();
      if (ram_rd_en) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 999;
        chk("rd_addr", 32'(ram_rd_addr), 32'(e));
        chk("busy_in_read", 32'(busy), 32'd1);
        reads++;
        if (toggle && ram_rd_addr == 6'd10) rd_flag = 1'b0;
        if (toggle && ram_rd_addr == 6'd12) rd_flag = 1'b1;
      end
      if (done) done_cyc = n;
    end
    chk("done_cycle", 32'(done_cyc), 32'd67);
    chk("read_count", 32'(reads), 32'(DEPTH));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("err", 32'(err), 32'(ecnt != 0));
    chk("err_cnt", 32'(err_cnt), 32'(ecnt));
    chk("first_err_addr", 32'(first_err_addr), 32'(efirst));
    if (!hold) rd_flag = 1'b0;
    extra = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done || busy || ram_rd_en) extra++;
    end
    chk("no_second_pass", 32'(extra), 32'd0);
    chk("err_cnt_held", 32'(err_cnt), 32'(ecnt));
    chk("first_held", 32'(first_err_addr), 32'(efirst));
    rd_flag = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int guard;
    int act;
    int done_cyc;
    rst      = 1'b0;
    rd_flag  = 1'b0;
    rd_flag2 = 1'b0;
    clean_mem();
    for (int i = 0; i < DEPTH2; i++) mem2[i] = 8'(i) | 8'h80;
    tick();
    tick();
    chk("rst_en", 32'(ram_rd_en), 32'd0);
    chk("rst_addr", 32'(ram_rd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_first", 32'(first_err_addr), 32'd0);
    rst = 1'b1;
    tick();
    tick();

    // clean pass
    pass6(0, 0, 1'b0, 1'b0);
    // single corruption
    mem[17] = 8'hFF;
    pass6(1, 17, 1'b0, 1'b0);
    // multiple corruptions
    clean_mem();
    mem[5] = 8'hFF; mem[40] = 8'hFF; mem[63] = 8'hFF;
    pass6(3, 5, 1'b0, 1'b0);
    // next clean pass clears everything
    clean_mem();
    pass6(0, 0, 1'b0, 1'b0);
    // flag held high well past the pass
    pass6(0, 0, 1'b0, 1'b1);
    // low->high toggle during READ is ignored, with a corruption to track
    mem[2] = 8'h00;
    pass6(1, 2, 1'b1, 1'b0);
    clean_mem();

    // reset mid-pass at address 30 after a mismatch at 5
    mem[5] = 8'hFF;
    rd_flag = 1'b1;
    guard = 0;
    while (!(ram_rd_en && ram_rd_addr == 6'd30) && guard < 200) begin
      tick();
      guard++;
    end
    chk("reached_addr30", 32'(ram_rd_addr), 32'd30);
    chk("err_before_rst", 32'(err), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_en", 32'(ram_rd_en), 32'd0);
    chk("abort_addr", 32'(ram_rd_addr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_err_cnt", 32'(err_cnt), 32'd0);
    chk("abort_first", 32'(first_err_addr), 32'd0);
    rd_flag = 1'b0;
    act = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (done || busy) act++;
    end
    rst = 1'b1;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (done || busy || ram_rd_en) act++;
    end
    chk("no_done_after_abort", 32'(act), 32'd0);
    mem[5] = 8'd5;
    pass6(0, 0, 1'b0, 1'b0);

    // AW=2 all-wrong RAM, repeated passes
    for (int p = 0; p < 3; p++) begin
      rd_flag2 = 1'b1;
      done_cyc = -1;
      for (int n = 1; n <= 50 && done_cyc < 0; n++) begin
        tick();
        if (n == 2) chk("sat_cleared_at_start", 32'(err_cnt2), 32'd0);
        if (done2) done_cyc = n;
      end
      chk("sat_done_cycle", 32'(done_cyc), 32'(DEPTH2 + 3));
      chk("sat_err", 32'(err2), 32'd1);
      chk("sat_err_cnt", 32'(err_cnt2), 32'd4);
      chk("sat_first", 32'(first_err_addr2), 32'd0);
      rd_flag2 = 1'b0;
      tick();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
